// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and state encoding for the MNIST output-stage sequencer
// Holds the layer geometry defaults, derived chunk count / widths and the FSM state enum.
package nn_pkg;

   localparam int N_IN      = 784;   // binary input features
   localparam int N_OUT     = 10;    // output neurons (<= 16, prediction is 4 bits)
   localparam int CHUNK     = 16;    // features consumed per ROM word
   localparam int W_BITS    = 8;     // signed weight width
   localparam int ACC_BITS  = 24;    // signed accumulator width

   localparam int C         = (N_IN + CHUNK - 1) / CHUNK;   // ROM words per neuron
   localparam int ADDR_BITS = $clog2(N_OUT * C);
   localparam int K_BITS    = $clog2(C);
   localparam int N_BITS    = 4;
   localparam int FEAT_BITS = C * CHUNK;                    // feature vector padded to whole chunks
   localparam int FIDX_BITS = $clog2(FEAT_BITS + 1);        // wide enough to also hold N_IN itself

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      CMP,
      DONE
   } state_t;

endpackage

// File: rtl/nn_chunk_mac.sv
// rtl/nn_chunk_mac.sv - combinational masked, sign-extending sum over one ROM word
// Ports:
//   w_data     : CHUNK signed weights, lane l = w_data[l*W_BITS +: W_BITS]
//   lane_feat  : feature bit for each lane (1 = pixel set)
//   lane_valid : 0 for lanes that fall past N_IN in the last chunk
//   sum        : sum of weights whose lane is both set and valid, sign-extended
module nn_chunk_mac
   import nn_pkg::*;
(
   input  logic [CHUNK*W_BITS-1:0]   w_data,
   input  logic [CHUNK-1:0]          lane_feat,
   input  logic [CHUNK-1:0]          lane_valid,
   output logic [ACC_BITS-1:0]       sum
);

   always_comb begin
      sum = '0;
      for (int l = 0; l < CHUNK; l++) begin
         if (lane_feat[l] && lane_valid[l]) begin
            sum = sum + {{(ACC_BITS-W_BITS){w_data[l*W_BITS+W_BITS-1]}},
                         w_data[l*W_BITS +: W_BITS]};
         end
      end
   end

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - output-layer sequencer: chunked weight fetch, accumulate, argmax
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   start, in_features : begin inference on the captured feature vector (accepted in IDLE only)
//   w_addr, w_rd_en    : synchronous weight ROM request, word n*C+k
//   w_data             : ROM word, valid the cycle after w_rd_en
//   prediction         : winning neuron index, max_score : its accumulator value
//   busy               : high from the cycle after acceptance until DONE exits
//   done               : one-cycle result-valid pulse
module nn_layer_sequencer
   import nn_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [N_IN-1:0]            in_features,
   output logic [ADDR_BITS-1:0]       w_addr,
   output logic                       w_rd_en,
   input  logic [CHUNK*W_BITS-1:0]    w_data,
   output logic [3:0]                 prediction,
   output logic signed [ACC_BITS-1:0] max_score,
   output logic                       busy,
   output logic                       done
);

   state_t                     state_q, state_d;
   logic [FEAT_BITS-1:0]       feat_q;
   logic [N_BITS-1:0]          n_q;
   logic [K_BITS-1:0]          k_q;
   logic [K_BITS-1:0]          k_d_q;        // chunk index of the word arriving this cycle
   logic [ADDR_BITS-1:0]       addr_q;       // tracks n*C+k incrementally
   logic                       acc_vld_q;    // a ROM word addressed last cycle is on w_data
   logic signed [ACC_BITS-1:0] acc_q;
   logic signed [ACC_BITS-1:0] best_q;
   logic [N_BITS-1:0]          best_idx_q;
   logic                       best_vld_q;

   logic [CHUNK-1:0]           lane_feat;
   logic [CHUNK-1:0]           lane_valid;
   logic [FIDX_BITS-1:0]       idx;
   logic signed [ACC_BITS-1:0] mac_sum;
   logic                       last_k, last_n, take;
   logic signed [ACC_BITS-1:0] new_best;
   logic [N_BITS-1:0]          new_idx;

   assign last_k = (k_q == K_BITS'(C - 1));
   assign last_n = (n_q == N_BITS'(N_OUT - 1));

   // Feature lanes follow the word on w_data, i.e. the chunk addressed one cycle ago.
   always_comb begin
      idx        = '0;
      lane_feat  = '0;
      lane_valid = '0;
      for (int l = 0; l < CHUNK; l++) begin
         idx           = FIDX_BITS'(k_d_q) * FIDX_BITS'(CHUNK) + FIDX_BITS'(l);
         lane_valid[l] = (idx < FIDX_BITS'(N_IN));
         lane_feat[l]  = feat_q[idx];
      end
   end

   nn_chunk_mac u_mac (
      .w_data     (w_data),
      .lane_feat  (lane_feat),
      .lane_valid (lane_valid),
      .sum        (mac_sum)
   );

   // Strictly greater keeps the lower index on ties; the first neuron always seeds best.
   always_comb begin
      take     = !best_vld_q || (acc_q > best_q);
      new_best = take ? acc_q : best_q;
      new_idx  = take ? n_q : best_idx_q;
   end

   always_comb begin
      state_d = state_q;
      w_rd_en = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      w_addr  = addr_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = FETCH;
         end
         FETCH: begin
            w_rd_en = 1'b1;
            busy    = 1'b1;
            if (last_k) state_d = DRAIN;
         end
         DRAIN: begin
            busy    = 1'b1;
            state_d = CMP;
         end
         CMP: begin
            busy    = 1'b1;
            state_d = last_n ? DONE : FETCH;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         feat_q     <= '0;
         n_q        <= '0;
         k_q        <= '0;
         k_d_q      <= '0;
         addr_q     <= '0;
         acc_vld_q  <= 1'b0;
         acc_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         best_vld_q <= 1'b0;
         prediction <= '0;
         max_score  <= '0;
      end else begin
         state_q   <= state_d;
         acc_vld_q <= (state_q == FETCH);
         k_d_q     <= k_q;
         if (acc_vld_q) acc_q <= acc_q + mac_sum;
         case (state_q)
            IDLE: begin
               if (start) begin
                  feat_q     <= FEAT_BITS'(in_features);
                  n_q        <= '0;
                  k_q        <= '0;
                  addr_q     <= '0;
                  acc_q      <= '0;
                  best_vld_q <= 1'b0;
               end
            end
            FETCH: begin
               // k holds at C-1 so the next neuron's first word is simply addr+1.
               if (!last_k) begin
                  k_q    <= k_q + 1'b1;
                  addr_q <= addr_q + 1'b1;
               end
            end
            CMP: begin
               best_q     <= new_best;
               best_idx_q <= new_idx;
               best_vld_q <= 1'b1;
               acc_q      <= '0;
               if (last_n) begin
                  prediction <= new_idx;
                  max_score  <= new_best;
               end else begin
                  n_q    <= n_q + 1'b1;
                  k_q    <= '0;
                  addr_q <= addr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - self-checking bench for nn_layer_sequencer
module tb_nn_layer_sequencer;
   import nn_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       start;
   logic [N_IN-1:0]            in_features;
   logic [ADDR_BITS-1:0]       w_addr;
   logic                       w_rd_en;
   logic [CHUNK*W_BITS-1:0]    w_data = '0;
   logic [3:0]                 prediction;
   logic signed [ACC_BITS-1:0] max_score;
   logic                       busy;
   logic                       done;

   always #5 clk = ~clk;

   nn_layer_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_features (in_features),
      .w_addr      (w_addr),
      .w_rd_en     (w_rd_en),
      .w_data      (w_data),
      .prediction  (prediction),
      .max_score   (max_score),
      .busy        (busy),
      .done        (done)
   );

   logic [CHUNK*W_BITS-1:0] rom [N_OUT*C];
   always @(posedge clk) if (w_rd_en) w_data <= rom[w_addr];

   localparam longint LAT  = N_OUT * (C + 2);   // 510
   localparam longint BUSY = LAT + 1;           // FETCH..DONE inclusive
   localparam longint PER  = LAT + 2;           // accept-to-accept when start is held

   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] pred;
      longint     score;
      longint     e0;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      string  name;
      int     rom_mode;
      int     img_mode;
      bit     use_model;
      int     exp_pred;
      longint exp_score;
   } vec_t;

   logic [3:0] cur_pred;
   longint     cur_score;
   longint     next_free = 0;
   longint     done_cnt  = 0;
   int         busy_cnt, addr_err, fetch_cnt, exp_addr;

   task automatic check(input string name, input longint act, input longint want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Monitor and acceptance model; sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         done_cnt++;
         if (sbq.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = sbq.pop_front();
            check("prediction", longint'(prediction), longint'(e.pred));
            check("max_score", longint'(max_score), e.score);
            check("done_latency", cyc - e.e0, LAT);
         end
      end
      if (busy) busy_cnt++;
      if (w_rd_en) begin
         if (int'(w_addr) != exp_addr) addr_err++;
         exp_addr++;
         fetch_cnt++;
      end
      if (rst) begin
         sbq.delete();
         next_free = 0;
      end else if (start && (cyc + 1 >= next_free)) begin
         e.pred  = cur_pred;
         e.score = cur_score;
         e.e0    = cyc + 1;
         sbq.push_back(e);
         next_free = cyc + 1 + PER;
         exp_addr  = 0;
      end
   end

   task automatic set_w(input int n, input int i, input logic [7:0] v);
      rom[n*C + i/CHUNK][(i%CHUNK)*W_BITS +: W_BITS] = v;
   endtask

   task automatic build_rom(input int mode);
      for (int a = 0; a < N_OUT*C; a++)
         rom[a] = (mode == 0) ? {$urandom(), $urandom(), $urandom(), $urandom()} : '0;
      for (int n = 0; n < N_OUT; n++)
         for (int i = 0; i < FEAT_BITS; i++)
            case (mode)
               1: if (n == 7) set_w(n, i, 8'd1);
               2: set_w(n, i, (n == 3 || n == 5) ? 8'd40 : -8'sd5);
               3: set_w(n, i, 8'hFF);
               4: if (n == 9 && i >= (C-1)*CHUNK) set_w(n, i, (i == N_IN-1) ? 8'd100 : 8'd127);
               default: ;
            endcase
   endtask

   task automatic build_img(input int mode);
      in_features = '0;
      case (mode)
         1: for (int i = 0; i < 20; i++) in_features[i*37] = 1'b1;
         2: in_features[100] = 1'b1;
         3: in_features[N_IN-1] = 1'b1;
         4: for (int i = 0; i < N_IN; i++) in_features[i] = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic model(output logic [3:0] p, output longint s);
      longint acc;
      logic signed [7:0] wv;
      p = 0;
      s = 0;
      for (int n = 0; n < N_OUT; n++) begin
         acc = 0;
         for (int i = 0; i < N_IN; i++)
            if (in_features[i]) begin
               wv = rom[n*C + i/CHUNK][(i%CHUNK)*W_BITS +: W_BITS];
               acc += longint'(wv);
            end
         if (n == 0 || acc > s) begin
            s = acc;
            p = 4'(n);
         end
      end
   endtask

   task automatic wait_done(input longint target);
      int t = 0;
      while (done_cnt < target && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("done_seen", longint'(done_cnt >= target), 1);
   endtask

   task automatic run_one();
      longint target;
      busy_cnt  = 0;
      addr_err  = 0;
      fetch_cnt = 0;
      target    = done_cnt + 1;
      start     = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      in_features = ~in_features;     // must not affect the captured run
      wait_done(target);
      repeat (3) @(posedge clk);
      #1;
      check("busy_cycles", busy_cnt, BUSY);
      check("addr_errors", addr_err, 0);
      check("fetch_count", fetch_cnt, N_OUT*C);
      check("hold_pred", longint'(prediction), longint'(cur_pred));
      check("extra_done", done_cnt, target);
   endtask

   task automatic check_reset_outputs();
      check("rst_prediction", longint'(prediction), 0);
      check("rst_max_score", longint'(max_score), 0);
      check("rst_done", longint'(done), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_w_rd_en", longint'(w_rd_en), 0);
      check("rst_w_addr", longint'(w_addr), 0);
   endtask

   vec_t   tbl[6];
   longint base;

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      in_features = '0;
      cur_pred    = '0;
      cur_score   = 0;
      build_rom(0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      @(posedge clk); #1;

      tbl[0] = '{"zero_image",   0, 0, 1'b0, 0,   0};
      tbl[1] = '{"neuron7_ones", 1, 1, 1'b0, 7,  20};
      tbl[2] = '{"tie_3_5",      2, 2, 1'b0, 3,  40};
      tbl[3] = '{"all_negative", 3, 1, 1'b0, 0, -20};
      tbl[4] = '{"padding_last", 4, 3, 1'b0, 9, 100};
      tbl[5] = '{"random",       0, 4, 1'b1, 0,   0};

      for (int v = 0; v < 6; v++) begin
         build_rom(tbl[v].rom_mode);
         build_img(tbl[v].img_mode);
         if (tbl[v].use_model) model(cur_pred, cur_score);
         else begin
            cur_pred  = 4'(tbl[v].exp_pred);
            cur_score = tbl[v].exp_score;
         end
         run_one();
      end

      // start held high: one done per run, restart right after DONE
      build_rom(1);
      build_img(1);
      cur_pred  = 4'd7;
      cur_score = 20;
      base      = done_cnt;
      start     = 1'b1;
      repeat (600) @(posedge clk);
      #1;
      start = 1'b0;
      check("held_start_dones", done_cnt, base + 1);
      wait_done(base + 2);

      // a second start mid-run is ignored
      base  = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      check("midrun_start_dones", done_cnt, base + 1);

      // reset mid-operation, then a fresh run
      base  = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs();
      rst = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      check("aborted_no_done", done_cnt, base);
      build_rom(2);
      build_img(2);
      cur_pred  = 4'd3;
      cur_score = 40;
      run_one();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
